convolution_accelerator: RTL and testbench
==========================================

Name: convolution_accelerator

Overview:
- Streaming 3x3 integer convolution engine.
- A host pushes words into an input FIFO: 9 filter coefficients first, then a 9-word image window, then 3-word columns that slide the window one column right.
- After each complete window the engine produces one multiply-accumulate result on finalsum and raises cReady.
- Sits between a host or processor write port and downstream result capture.

Parameters:
- DATA_W, 16: width of dataInput, coefficients, pixels and finalsum. Values are two's complement.
- FIFO_DEPTH, 16: input FIFO depth in words. Must be a power of two.

Ports:
- Clk  in  1  system clock; all logic is in this single domain.
- Rst  in  1  asynchronous, active-high reset.
- dataInput  in  DATA_W  word to push into the FIFO.
- cStart  in  1  level enable for the engine. Low forces IDLE.
- newline  in  1  when high, the next window fetch is a full 9-word reload instead of a 3-word column.
- wr  in  1  write enable qualifying wr_clk.
- wr_clk  in  1  write strobe. Synchronised into Clk; a push happens on its rising edge.
- finalsum  out  DATA_W  convolution result.
- cReady  out  1  result valid.
- FULL  out  1  FIFO full.
- EMPTY  out  1  FIFO empty.

Behaviour:
- Reset: FIFO cleared; EMPTY=1, FULL=0, finalsum=0, cReady=0; state IDLE; coefficient and window registers zeroed.
- Write path:
  - wr_clk passes through a 2-flop synchroniser and a rising-edge detector.
  - On a detected edge with the synchronised wr=1 and FULL=0, push dataInput, sampled with the edge.
  - A push while FULL is dropped; no flag changes.
  - Each wr_clk phase must be held at least 3 Clk periods.
- FIFO behaviour:
  - Synchronous flags. EMPTY updates the cycle after the last pop; FULL updates when the count reaches FIFO_DEPTH.
  - Simultaneous push and pop keeps the count unchanged.
- State machine:
  - IDLE: cReady=0. Go to LOAD_COEF when cStart=1.
  - LOAD_COEF: pop 9 words into K[0..8] in row-major order, one pop per cycle when EMPTY=0. Then go to LOAD_WIN.
  - LOAD_WIN: pop 9 words into window W[r][c], row-major. Then go to MAC.
  - LOAD_COL: pop 3 words (top, middle, bottom). On each row the window shifts left by one column: W[r][0]=W[r][1], W[r][1]=W[r][2], W[r][2]=new. Then go to MAC.
  - MAC: one multiplier, 9 cycles, acc += K[i]*W[i], i=0..8. Full-precision accumulator; result truncated to DATA_W (wraps). Then go to DONE.
  - DONE: load finalsum and set cReady=1. Go to LOAD_COL, or to LOAD_WIN if newline was seen high at any point since the previous DONE.
- cReady:
  - Stays high, and finalsum holds, until the first pop of the next window or column fetch.
  - Latency: cReady rises 11 Clk cycles after the pop of the last window or column word.
- cStart: deasserting cStart in any state returns the engine to IDLE next cycle.
  - Clears cReady and the coefficients.
  - Keeps FIFO contents and finalsum.
  - The next start reloads coefficients.
- Reset mid-operation: immediate return to the reset values above.
- Starvation: while EMPTY=1 the load states simply wait. No timeout.

Optional Feature:
- Macro CONV_SATURATE_EN.
- Defined: the accumulator result is clamped to the signed DATA_W range, -2^(DATA_W-1) to 2^(DATA_W-1)-1, before loading finalsum.
- Undefined: plain truncation (wrap).

Test Plan:
- Reset: assert Rst -> EMPTY=1, FULL=0, cReady=0, finalsum=0.
- Base window:
  - cStart=1, push coefficients 0,1,0,1,0,1,0,1,0, then window 3,6,9,12,15,18,21,24,27.
  - Required: cReady=1, finalsum=60.
- Column slides:
  - After the base window, push column 13,0,12 -> cReady falls, then rises with finalsum=51.
  - Then push column 0,23,69 -> finalsum=66.
- newline reload:
  - After the first result, pulse newline, then push 9 words all 1.
  - Required: finalsum=4, computed as a full reload, not a slide.
- FIFO limits:
  - With cStart=0, push FIFO_DEPTH+2 words -> FULL=1 and the extras are dropped.
  - Raise cStart -> the engine pops, FULL clears, and EMPTY sets after the words are consumed.
- Overflow:
  - All coefficients 0x7FFF and window 0x7FFF (DATA_W=16).
  - Required: finalsum equals the truncated 16-bit sum; 0x7FFF with CONV_SATURATE_EN defined.
- Abort:
  - Drop cStart mid-MAC -> IDLE, cReady stays 0.
  - Raise cStart again -> the next 9 words are taken as coefficients.

Source files
------------

// File: rtl/convolution_accelerator.sv
// convolution_accelerator: streaming 3x3 integer convolution engine.
//
// A host pushes words through an asynchronous write strobe (wr_clk, qualified
// by wr) into an input FIFO: 9 coefficients, then a 9-word window, then
// 3-word columns that slide the window one column right. After each window a
// single-multiplier MAC produces finalsum and raises cReady.
//
// Ports:
//   Clk, Rst    system clock, asynchronous active-high reset
//   dataInput   word pushed on a synchronised rising edge of wr_clk (wr=1)
//   cStart      level enable; low returns the engine to IDLE
//   newline     next window fetch is a full 9-word reload
//   wr, wr_clk  host write enable / write strobe (synchronised into Clk)
//   finalsum    convolution result, cReady marks it valid
//   FULL, EMPTY input FIFO flags
//
// Optional feature: define CONV_SATURATE_EN to clamp the accumulator to the
// signed DATA_W range instead of wrapping.
module convolution_accelerator #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] dataInput,
  input  logic              cStart,
  input  logic              newline,
  input  logic              wr,
  input  logic              wr_clk,
  output logic [DATA_W-1:0] finalsum,
  output logic              cReady,
  output logic              FULL,
  output logic              EMPTY
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int ACC_W = 2 * DATA_W + 4;

  typedef enum logic [2:0] {IDLE, LOAD_COEF, LOAD_WIN, LOAD_COL, MAC, DONE} state_t;
  state_t state, nstate;

  // write strobe synchroniser + rising-edge detector
  logic [2:0] wclk_s;
  logic [1:0] wr_s;
  logic       push, pop;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wclk_s <= '0;
      wr_s   <= '0;
    end else begin
      wclk_s <= {wclk_s[1:0], wr_clk};
      wr_s   <= {wr_s[0], wr};
    end
  end

  assign push = wclk_s[1] & ~wclk_s[2] & wr_s[1] & ~FULL;

  // input FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] rdata;

  always_ff @(posedge Clk) begin
    if (push) mem[wptr] <= dataInput;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign FULL  = (count == CW'(FIFO_DEPTH));
  assign EMPTY = (count == '0);

  // engine
  logic signed [DATA_W-1:0]   k [9];
  logic signed [DATA_W-1:0]   w [9];
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;
  logic [3:0]                 idx;
  logic [3:0]                 rb;
  logic                       nl_seen, nl_pend, redirect;
  logic [DATA_W-1:0]          result;

  assign nl_pend  = nl_seen | newline;
  // a column fetch that has not popped anything yet is turned into a reload
  assign redirect = (state == LOAD_COL) && (idx == 4'd0) && nl_pend;
  assign rb       = (idx == 4'd0) ? 4'd0 : (idx == 4'd1) ? 4'd3 : 4'd6;

`ifdef CONV_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  always_comb begin
    result = acc[DATA_W-1:0];
    if (acc > SMAX)      result = SMAX[DATA_W-1:0];
    else if (acc < SMIN) result = SMIN[DATA_W-1:0];
  end
`else
  logic unused_acc;
  assign result     = acc[DATA_W-1:0];
  assign unused_acc = ^acc[ACC_W-1:DATA_W];
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    pop    = 1'b0;
    case (state)
      IDLE:      if (cStart) nstate = LOAD_COEF;
      LOAD_COEF: if (!EMPTY) begin
                   pop = 1'b1;
                   if (idx == 4'd8) nstate = LOAD_WIN;
                 end
      LOAD_WIN:  if (!EMPTY) begin
                   pop = 1'b1;
                   if (idx == 4'd8) nstate = MAC;
                 end
      LOAD_COL:  if (redirect) nstate = LOAD_WIN;
                 else if (!EMPTY) begin
                   pop = 1'b1;
                   if (idx == 4'd2) nstate = MAC;
                 end
      MAC:       if (idx == 4'd9) nstate = DONE;
      DONE:      nstate = nl_pend ? LOAD_WIN : LOAD_COL;
      default:   nstate = IDLE;
    endcase
    if (!cStart) begin
      nstate = IDLE;
      pop    = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int unsigned i = 0; i < 9; i++) begin
        k[i] <= '0;
        w[i] <= '0;
      end
      prod     <= '0;
      acc      <= '0;
      idx      <= '0;
      nl_seen  <= 1'b0;
      finalsum <= '0;
      cReady   <= 1'b0;
    end else if (!cStart) begin
      for (int unsigned i = 0; i < 9; i++) k[i] <= '0;
      idx     <= '0;
      nl_seen <= 1'b0;
      cReady  <= 1'b0;
    end else begin
      if (state == DONE || redirect) nl_seen <= 1'b0;
      else if (newline)              nl_seen <= 1'b1;
      case (state)
        IDLE: idx <= '0;
        LOAD_COEF: if (pop) begin
          k[idx] <= rdata;
          idx    <= (idx == 4'd8) ? 4'd0 : idx + 4'd1;
        end
        LOAD_WIN: if (pop) begin
          w[idx] <= rdata;
          cReady <= 1'b0;
          idx    <= (idx == 4'd8) ? 4'd0 : idx + 4'd1;
        end
        LOAD_COL: if (pop) begin
          w[rb]        <= w[rb + 4'd1];
          w[rb + 4'd1] <= w[rb + 4'd2];
          w[rb + 4'd2] <= rdata;
          cReady       <= 1'b0;
          idx          <= (idx == 4'd2) ? 4'd0 : idx + 4'd1;
        end
        // registered product: issue k*w on idx 0..8, accumulate one cycle later
        MAC: begin
          if (idx != 4'd9) prod <= k[idx] * w[idx];
          acc <= (idx == 4'd0) ? '0 : acc + ACC_W'(prod);
          idx <= (idx == 4'd9) ? 4'd0 : idx + 4'd1;
        end
        DONE: begin
          finalsum <= result;
          cReady   <= 1'b1;
        end
        default: idx <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_convolution_accelerator.sv
module tb_convolution_accelerator;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] dataInput;
  logic        cStart, newline, wr, wr_clk;
  logic [15:0] finalsum;
  logic        cReady, FULL, EMPTY;

  int checks = 0;
  int errors = 0;

  convolution_accelerator #(.DATA_W(16), .FIFO_DEPTH(16)) dut (
    .Clk(Clk), .Rst(Rst), .dataInput(dataInput), .cStart(cStart),
    .newline(newline), .wr(wr), .wr_clk(wr_clk), .finalsum(finalsum),
    .cReady(cReady), .FULL(FULL), .EMPTY(EMPTY)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    @(negedge Clk);
    dataInput = v;
    wr        = 1'b1;
    wr_clk    = 1'b1;
    repeat (4) @(negedge Clk);
    wr_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  // push one word and count cycles from its pop (EMPTY rising) to cReady
  task automatic push_meas(input logic [15:0] v, output int lat);
    int n;
    @(negedge Clk);
    dataInput = v;
    wr        = 1'b1;
    wr_clk    = 1'b1;
    n = 0;
    while (EMPTY && n < 20) begin @(negedge Clk); n++; end
    n = 0;
    while (!EMPTY && n < 20) begin @(negedge Clk); n++; end
    lat = 0;
    while (!cReady && lat < 100) begin @(negedge Clk); lat++; end
    wr_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!cReady && n < 200) begin @(negedge Clk); n++; end
    chk(tag, {31'd0, cReady}, 32'd1);
  endtask

  initial begin
    logic [15:0] coef_a [9];
    logic [15:0] ovf_exp;
    logic [15:0] v;
    int          lat;
    logic        seen;

    coef_a = '{16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0};
`ifdef CONV_SATURATE_EN
    ovf_exp = 16'h7FFF;
`else
    ovf_exp = 16'h0009;   // 9 * 0x3FFF0001 truncated to 16 bits
`endif

    Rst = 1'b1; cStart = 1'b0; newline = 1'b0; wr = 1'b0; wr_clk = 1'b0; dataInput = '0;
    repeat (3) @(negedge Clk);
    chk("rst_empty", {31'd0, EMPTY}, 32'd1);
    chk("rst_full", {31'd0, FULL}, 32'd0);
    chk("rst_ready", {31'd0, cReady}, 32'd0);
    chk("rst_sum", {16'd0, finalsum}, 32'd0);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);

    // base window
    cStart = 1'b1;
    for (int i = 0; i < 9; i++) push(coef_a[i]);
    for (int i = 1; i < 9; i++) push(16'(3 * i));
    push_meas(16'd27, lat);
    chk("base_ready", {31'd0, cReady}, 32'd1);
    chk("base_sum", {16'd0, finalsum}, 32'd60);
    chk("latency", lat, 32'd11);
    repeat (5) @(negedge Clk);
    chk("hold_ready", {31'd0, cReady}, 32'd1);
    chk("hold_sum", {16'd0, finalsum}, 32'd60);

    // column slides
    push(16'd13);
    chk("col1_fall", {31'd0, cReady}, 32'd0);
    push(16'd0);
    push(16'd12);
    wait_ready("col1_ready");
    chk("col1_sum", {16'd0, finalsum}, 32'd51);
    push(16'd0); push(16'd23); push(16'd69);
    wait_ready("col2_ready");
    chk("col2_sum", {16'd0, finalsum}, 32'd66);

    // newline reload
    @(negedge Clk) newline = 1'b1;
    @(negedge Clk) newline = 1'b0;
    for (int i = 0; i < 9; i++) push(16'd1);
    wait_ready("nl_ready");
    chk("nl_sum", {16'd0, finalsum}, 32'd4);

    // stop keeps finalsum, clears cReady
    cStart = 1'b0;
    repeat (3) @(negedge Clk);
    chk("stop_ready", {31'd0, cReady}, 32'd0);
    chk("stop_sum", {16'd0, finalsum}, 32'd4);

    // overflow
    cStart = 1'b1;
    for (int i = 0; i < 18; i++) push(16'h7FFF);
    wait_ready("ovf_ready");
    chk("ovf_sum", {16'd0, finalsum}, {16'd0, ovf_exp});

    // abort during MAC
    for (int i = 0; i < 3; i++) push(16'h7FFF);
    cStart = 1'b0;
    seen = 1'b0;
    repeat (30) begin @(negedge Clk); if (cReady) seen = 1'b1; end
    chk("abort_ready", {31'd0, seen}, 32'd0);
    chk("abort_sum", {16'd0, finalsum}, {16'd0, ovf_exp});
    cStart = 1'b1;
    for (int i = 0; i < 9; i++) push((i == 4) ? 16'd2 : 16'd0);
    for (int i = 1; i <= 9; i++) push(16'(i));
    wait_ready("restart_ready");
    chk("restart_sum", {16'd0, finalsum}, 32'd10);

    // FIFO limits: 18 pushes while stopped, last two must be dropped
    cStart = 1'b0;
    repeat (2) @(negedge Clk);
    for (int i = 1; i <= 18; i++) begin
      if (i <= 7)       v = 16'd0;
      else if (i <= 9)  v = 16'd1;
      else if (i <= 16) v = 16'(17 * i);
      else if (i == 17) v = 16'h0100;
      else              v = 16'h0200;
      push(v);
      if (i == 16) chk("full_at_depth", {31'd0, FULL}, 32'd1);
    end
    chk("full_after_extra", {31'd0, FULL}, 32'd1);
    chk("notempty_full", {31'd0, EMPTY}, 32'd0);
    cStart = 1'b1;
    repeat (30) @(negedge Clk);
    chk("drain_full", {31'd0, FULL}, 32'd0);
    chk("drain_empty", {31'd0, EMPTY}, 32'd1);
    chk("drain_ready", {31'd0, cReady}, 32'd0);
    push(16'd5);
    push(16'd7);
    wait_ready("drop_ready");
    chk("drop_sum", {16'd0, finalsum}, 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
